// File: rtl/game_score_timer.sv
`default_nettype none
// ============================================================================
// Module   : game_score_timer
// Brief    : Reaction-game countdown, round timer and saturating BCD score
//            with streak bonus, wrong-answer penalty, pause and seven-segment
//            (active-low) digit outputs.
// Revision : 1.0 - initial release
// ============================================================================
module game_score_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int PRESTART  = 3,
    parameter int GAME_TIME = 60,
    parameter int STREAK_N  = 3,
    parameter int BONUS     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       button_left,
    input  logic       button_right,
    input  logic       correct,
    output logic [6:0] time_seg,
    output logic [6:0] time10_seg,
    output logic [6:0] score_seg,
    output logic [6:0] score10_seg,
    output logic [2:0] game_state,
    output logic       done
);

    localparam int               DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [3:0]       PRE_O      = 4'(PRESTART);
    localparam logic [3:0]       GT_T       = 4'(GAME_TIME / 10);
    localparam logic [3:0]       GT_O       = 4'(GAME_TIME % 10);
    localparam logic [3:0]       BONUS_V    = 4'(BONUS);
    localparam logic [2:0]       STREAK_MAX = 3'(STREAK_N);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Input pipeline, bit order {start, pause, left, right}
    logic [3:0] in_s1_q, in_s2_q, in_s3_q, edge_q;
    logic       corr_s1_q, corr_s2_q, corr_q;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       time_t_q, time_t_d, time_o_q, time_o_d;
    logic [3:0]       score_t_q, score_t_d, score_o_q, score_o_d;
    logic [2:0]       streak_q, streak_d;
    logic             done_q, done_d;

    logic       start_edge, pause_edge, answer_edge, tick, time_one;
    logic [3:0] dec_t, dec_o, score_inc;
    logic [6:0] score_bin, score_up, score_dn, score_new;

    // Two-stage synchroniser plus registered rising-edge detect; correct is
    // delayed by the same depth so it lines up with the answer edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_s1_q   <= 4'd0;
            in_s2_q   <= 4'd0;
            in_s3_q   <= 4'd0;
            edge_q    <= 4'd0;
            corr_s1_q <= 1'b0;
            corr_s2_q <= 1'b0;
            corr_q    <= 1'b0;
        end else begin
            in_s1_q   <= {start, pause, button_left, button_right};
            in_s2_q   <= in_s1_q;
            in_s3_q   <= in_s2_q;
            edge_q    <= in_s2_q & ~in_s3_q;
            corr_s1_q <= correct;
            corr_s2_q <= corr_s1_q;
            corr_q    <= corr_s2_q;
        end
    end

    assign start_edge  = edge_q[3];
    assign pause_edge  = edge_q[2];
    assign answer_edge = edge_q[1] | edge_q[0];

    assign tick     = ((state_q == ST_READY) || (state_q == ST_RUN)) && (div_q == DIV_LAST);
    assign time_one = (time_t_q == 4'd0) && (time_o_q == 4'd1);
    assign dec_o    = (time_o_q == 4'd0) ? 4'd9 : time_o_q - 4'd1;
    assign dec_t    = (time_o_q == 4'd0) ? time_t_q - 4'd1 : time_t_q;

    // Score arithmetic in binary, saturating at 0 and 99
    always_comb begin
        score_bin = 7'(score_t_q) * 7'd10 + 7'(score_o_q);
        score_inc = (streak_q >= STREAK_MAX) ? BONUS_V : 4'd1;
        score_up  = score_bin + 7'(score_inc);
        if (score_up > 7'd99) begin
            score_up = 7'd99;
        end
        score_dn  = (score_bin == 7'd0) ? 7'd0 : score_bin - 7'd1;
        score_new = corr_q ? score_up : score_dn;
    end

    // Game state machine, divider, time and score next-state
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        time_t_d  = time_t_q;
        time_o_d  = time_o_q;
        score_t_d = score_t_q;
        score_o_d = score_o_q;
        streak_d  = streak_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                div_d = '0;
                if (start_edge) begin
                    score_t_d = 4'd0;
                    score_o_d = 4'd0;
                    streak_d  = 3'd0;
                    time_t_d  = 4'd0;
                    time_o_d  = PRE_O;
                    state_d   = ST_READY;
                end
            end
            ST_READY: begin
                div_d = tick ? '0 : div_q + DIV_ONE;
                if (tick) begin
                    if (time_one) begin
                        time_t_d = GT_T;
                        time_o_d = GT_O;
                        state_d  = ST_RUN;
                    end else begin
                        time_t_d = dec_t;
                        time_o_d = dec_o;
                    end
                end
            end
            ST_RUN: begin
                div_d = tick ? '0 : div_q + DIV_ONE;
                if (answer_edge) begin
                    score_t_d = 4'(score_new / 7'd10);
                    score_o_d = 4'(score_new % 7'd10);
                    if (corr_q) begin
                        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 3'd1;
                    end else begin
                        streak_d = 3'd0;
                    end
                end
                if (tick && time_one) begin
                    time_t_d = 4'd0;
                    time_o_d = 4'd0;
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                end else begin
                    if (tick) begin
                        time_t_d = dec_t;
                        time_o_d = dec_o;
                    end
                    if (pause_edge) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_edge) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            time_t_q  <= 4'd0;
            time_o_q  <= 4'd0;
            score_t_q <= 4'd0;
            score_o_q <= 4'd0;
            streak_q  <= 3'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            time_t_q  <= time_t_d;
            time_o_q  <= time_o_d;
            score_t_q <= score_t_d;
            score_o_q <= score_o_d;
            streak_q  <= streak_d;
            done_q    <= done_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign time_seg    = seg7(time_o_q);
    assign time10_seg  = seg7(time_t_q);
    assign score_seg   = seg7(score_o_q);
    assign score10_seg = seg7(score_t_q);
    assign game_state  = state_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_game_score_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_score_timer
// Brief    : Directed and randomised stimulus for game_score_timer, compared
//            every cycle against an integer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_score_timer;

    localparam int TICK_DIV  = 4;
    localparam int PRESTART  = 3;
    localparam int GAME_TIME = 20;
    localparam int STREAK_N  = 3;
    localparam int BONUS     = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, pause = 1'b0, bl = 1'b0, br = 1'b0, correct = 1'b0;
    logic [6:0] time_seg, time10_seg, score_seg, score10_seg;
    logic [2:0] game_state;
    logic       done;

    always #5 clock = ~clock;

    game_score_timer #(
        .TICK_DIV (TICK_DIV),
        .PRESTART (PRESTART),
        .GAME_TIME(GAME_TIME),
        .STREAK_N (STREAK_N),
        .BONUS    (BONUS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .button_left (bl),
        .button_right(br),
        .correct     (correct),
        .time_seg    (time_seg),
        .time10_seg  (time10_seg),
        .score_seg   (score_seg),
        .score10_seg (score10_seg),
        .game_state  (game_state),
        .done        (done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers, states 0 idle,1 ready,2 run,3 pause,4 done
    int m_state, m_time, m_score, m_streak, m_cnt, m_done;
    // Sampled input history, bit i = level seen i clock edges ago
    logic [4:0] h_start, h_pause, h_l, h_r, h_c;

    function automatic integer seg2dig(input logic [6:0] s);
        case (s)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            default:    return 100;
        endcase
    endfunction

    function automatic integer dut_time();
        return seg2dig(time10_seg) * 10 + seg2dig(time_seg);
    endfunction

    function automatic integer dut_score();
        return seg2dig(score10_seg) * 10 + seg2dig(score_seg);
    endfunction

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_time = 0; m_score = 0; m_streak = 0; m_cnt = 0; m_done = 0;
        h_start = '0; h_pause = '0; h_l = '0; h_r = '0; h_c = '0;
    endtask

    // An input level sampled at edge k takes effect on the update at edge k+3
    task automatic model_clock();
        logic se, pe, ae, cv, tk;
        h_start = {h_start[3:0], start};
        h_pause = {h_pause[3:0], pause};
        h_l     = {h_l[3:0], bl};
        h_r     = {h_r[3:0], br};
        h_c     = {h_c[3:0], correct};
        se = h_start[3] & ~h_start[4];
        pe = h_pause[3] & ~h_pause[4];
        ae = (h_l[3] & ~h_l[4]) | (h_r[3] & ~h_r[4]);
        cv = h_c[3];
        tk = ((m_state == 1) || (m_state == 2)) && (m_cnt == TICK_DIV - 1);
        m_done = 0;
        case (m_state)
            0, 4: begin
                m_cnt = 0;
                if (se) begin
                    m_score = 0; m_streak = 0; m_time = PRESTART; m_state = 1;
                end
            end
            1: begin
                if (tk) begin
                    m_cnt = 0;
                    if (m_time == 1) begin
                        m_time = GAME_TIME; m_state = 2;
                    end else begin
                        m_time--;
                    end
                end else begin
                    m_cnt++;
                end
            end
            2: begin
                if (ae) begin
                    if (cv) begin
                        m_score += (m_streak >= STREAK_N) ? BONUS : 1;
                        if (m_score > 99) m_score = 99;
                        if (m_streak < STREAK_N) m_streak++;
                    end else begin
                        if (m_score > 0) m_score--;
                        m_streak = 0;
                    end
                end
                if (tk) begin
                    m_cnt = 0;
                    if (m_time == 1) begin
                        m_time = 0; m_state = 4; m_done = 1;
                    end else begin
                        m_time--;
                    end
                end else begin
                    m_cnt++;
                end
                if (pe && m_state == 2) m_state = 3;
            end
            3: if (pe) m_state = 2;
            default: m_state = 0;
        endcase
    endtask

    task automatic check_outputs();
        check("state", game_state, m_state);
        check("done", done, m_done);
        check("time", dut_time(), m_time);
        check("score", dut_score(), m_score);
    endtask

    task automatic step();
        @(posedge clock);
        model_clock();
        #1;
        check_outputs();
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 100 && m_state != 2; i++) step();
        check(tag, game_state, 2);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && m_state != 4; i++) step();
        check(tag, game_state, 4);
    endtask

    initial begin
        int ready_cycles, run_cycles, done_cnt, steps;
        int exp_seq[7];
        int cor_seq[7];
        exp_seq = '{1, 2, 3, 5, 7, 6, 7};
        cor_seq = '{1, 1, 1, 1, 1, 0, 1};

        // Reset state is visible with no clock edge
        #3;
        check("rst_state", game_state, 0);
        check("rst_done", done, 0);
        check("rst_seg_t", time_seg, 7'b1000000);
        check("rst_seg_t10", time10_seg, 7'b1000000);
        check("rst_seg_s", score_seg, 7'b1000000);
        check("rst_seg_s10", score10_seg, 7'b1000000);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) step();

        // Round 1: random answers, measure READY and RUN lengths
        ready_cycles = 0; run_cycles = 0; done_cnt = 0;
        press_start();
        for (int i = 0; i < 400 && m_state != 4; i++) begin
            bl      = 1'($urandom_range(0, 1));
            br      = 1'($urandom_range(0, 1));
            correct = 1'($urandom_range(0, 1));
            start   = (m_state == 2 && m_time > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (game_state == 3'd1) ready_cycles++;
            if (game_state == 3'd2) run_cycles++;
            if (done) done_cnt++;
        end
        bl = 0; br = 0; correct = 0; start = 0;
        check("r1_end_state", game_state, 4);
        check("r1_ready_len", ready_cycles, PRESTART * TICK_DIV);
        check("r1_run_len", run_cycles, GAME_TIME * TICK_DIV);
        check("r1_done_pulses", done_cnt, 1);
        repeat (6) step();

        // Round 2: wrong answers at zero stay zero, then saturate at 99
        press_start();
        wait_run("r2_run");
        for (int i = 0; i < 6; i++) begin
            bl = (i % 2 == 0); br = (i % 2 == 1); correct = 0;
            step();
        end
        bl = 0; br = 0;
        repeat (4) step();
        check("floor_score", dut_score(), 0);
        for (int i = 0; i < 300 && m_state != 4; i++) begin
            bl = (i % 2 == 0); br = (i % 2 == 1); correct = 1;
            step();
        end
        bl = 0; br = 0; correct = 0;
        check("sat_state", game_state, 4);
        check("sat_score", dut_score(), 99);
        repeat (4) step();

        // Round 3: streak/penalty sequence, then pause at 07
        press_start();
        wait_run("r3_run");
        for (int i = 0; i < 7; i++) begin
            bl = 1; correct = 1'(cor_seq[i]);
            step();
            bl = 0;
            repeat (3) step();
            check("streak_seq", dut_score(), exp_seq[i]);
        end
        correct = 0;
        for (int i = 0; i < 400 && !(m_state == 2 && m_time == 8 && m_cnt == 2); i++) step();
        check("pre_pause_time", dut_time(), 8);
        // Pause edge lands after one more tick, with the divider at 2
        pause = 1; step(); pause = 0;
        repeat (3) step();
        check("pause_state", game_state, 3);
        check("pause_time", dut_time(), 7);
        for (int i = 0; i < 14; i++) begin
            bl = (i % 2 == 0); br = (i % 2 == 1); correct = 1'($urandom_range(0, 1));
            step();
        end
        bl = 0; br = 0; correct = 0;
        repeat (6) step();
        check("paused_time", dut_time(), 7);
        check("paused_score", dut_score(), 7);
        check("paused_state", game_state, 3);
        // Resume takes 4 edges, then the frozen divider needs TICK_DIV-2 more
        steps = 0;
        pause = 1; step(); steps++; pause = 0;
        while (steps < 20 && dut_time() != 6) begin
            step(); steps++;
        end
        check("resume_latency", steps, 4 + TICK_DIV - 2);
        wait_done("r3_done");
        repeat (3) step();

        // Round 4: both buttons land on the final tick
        press_start();
        for (int i = 0; i < 400 && !(m_state == 2 && m_time == 1 && m_cnt == 0); i++) step();
        check("last_second", dut_time(), 1);
        bl = 1; br = 1; correct = 1;
        step();
        bl = 0; br = 0;
        repeat (2) step();
        check("pre_final_state", game_state, 2);
        step();
        check("final_state", game_state, 4);
        check("final_done", done, 1);
        check("final_score", dut_score(), 1);
        check("final_time", dut_time(), 0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("done_once", done_cnt, 0);
        correct = 0;

        // Round 5: reach 37 then reset asynchronously mid-RUN
        press_start();
        wait_run("r5_run");
        for (int i = 0; i < 20; i++) begin
            bl = 1; correct = 1;
            step();
            bl = 0;
            step();
        end
        correct = 0;
        repeat (4) step();
        check("pre_reset_score", dut_score(), 37);
        check("pre_reset_state", game_state, 2);
        #2;
        reset = 1'b0;
        #1;
        check("async_state", game_state, 0);
        check("async_done", done, 0);
        check("async_seg_t", time_seg, 7'b1000000);
        check("async_seg_t10", time10_seg, 7'b1000000);
        check("async_seg_s", score_seg, 7'b1000000);
        check("async_seg_s10", score10_seg, 7'b1000000);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_score_timer.md
# game_score_timer

Parametrised scoring and countdown block for the reaction game. It replaces the fixed two-digit score counter and the 1 s divider with one unit. The unit runs a pre-start countdown, then a timed game round with pause, streak bonus, wrong-answer penalty and saturating BCD score. It drives four active-low seven-segment digits and a game-state code to the top-level game FSM.

## Interface
Parameters:
- TICK_DIV, 50000000 — clock cycles per game second (≥2)
- PRESTART, 3 — pre-start countdown seconds (1..9)
- GAME_TIME, 60 — round length in seconds (1..99)
- STREAK_N, 3 — consecutive correct answers before the bonus applies (1..7)
- BONUS, 2 — points per correct answer once the streak is reached (1..9)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  start button, active-high level
- pause  in  1  pause/resume button, active-high level
- button_left, button_right  in  1 each  answer buttons, active-high level
- correct  in  1  verdict for the current answer, sampled together with the answer edge
- time_seg, time10_seg  out  7 each  time digits (ones, tens), active-low
- score_seg, score10_seg  out  7 each  score digits (ones, tens), active-low
- game_state  out  3  0 IDLE, 1 READY, 2 RUN, 3 PAUSE, 4 DONE
- done  out  1  one-cycle pulse when the round ends

## Operation
- Input conditioning:
  - start, pause, button_left and button_right each pass through a 2-FF synchroniser, then a rising-edge detector.
  - answer_edge = left edge OR right edge. Both buttons rising in the same cycle count as one answer.
  - correct goes through the same 2-FF delay so it stays aligned with answer_edge.
- Tick divider:
  - Counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1.
  - Counts only in READY and RUN. Holds in PAUSE. Cleared to 0 in IDLE and DONE and on every entry to READY.
- Time and score are held in BCD: time_t/time_o (tens/ones) and score_t/score_o.
- Segment encoding, 0..9 active-low: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Outputs are combinational from the BCD registers.
- State machine:
  - IDLE: time = 00. On start edge: score = 00, streak = 0, time = PRESTART, go to READY.
  - READY: each tick decrements time. A tick with time == 01 loads GAME_TIME and goes to RUN; 00 is never shown in READY. Answers and pause are ignored.
  - RUN:
    - A tick with time == 01 sets time = 00, goes to DONE and pulses done for that cycle.
    - Any other tick decrements time with BCD borrow (e.g. 10 → 09).
    - pause edge goes to PAUSE.
    - start edge is ignored.
  - PAUSE: time, score and divider are frozen. pause edge returns to RUN. Answers are ignored.
  - DONE: time and score are held. start edge behaves as in IDLE and goes to READY.
- Scoring, applied only when answer_edge occurs in RUN:
  - correct = 1: add BONUS if streak ≥ STREAK_N, otherwise add 1. Then streak = min(streak+1, STREAK_N).
  - correct = 0: subtract 1, saturating at 00. streak = 0.
  - The sum saturates at 99 (e.g. 98 + 2 = 99).
- Simultaneous events:
  - An answer in the same cycle as the final tick is scored.
  - An answer in the same cycle as a pause edge is scored, then the block enters PAUSE.
  - A start edge in the same cycle as a pause edge in DONE or IDLE: start wins.

## Timing
- Reset (asynchronous, any state):
  - game_state = 0, done = 0, time = 00, score = 00, streak = 0, divider = 0, synchronisers = 0.
  - All four segment outputs = 1000000 immediately.
- Edge latency:
  - A level sampled high at posedge k produces its edge during cycle k+2.
  - The state/score/time register update happens at posedge k+3.
- First tick after entering READY or RUN: TICK_DIV cycles later.
- RUN lasts exactly GAME_TIME × TICK_DIV cycles of unpaused time. PAUSE adds no time.
- done is high for exactly one cycle, the cycle in which game_state first reads 4.

## Test plan
- Reset and segments: assert reset mid-RUN with score 37 → all digits show 1000000 and game_state = 0 asynchronously, with no clock edge needed.
- Full round (TICK_DIV=4, PRESTART=3, GAME_TIME=12): start → time shows 3, 2, 1, then 12…01, 00 → READY lasts 12 cycles, RUN lasts 48 cycles, done pulses once, game_state = 4.
- Streak and penalty (STREAK_N=3, BONUS=2): correct ×5, wrong, correct → score 1, 2, 3, 5, 7, 6, 7.
- Saturation: force score to 98, then two correct answers with bonus → 99, 99. Score 00 plus a wrong answer → 00.
- Pause (TICK_DIV=4): pause at time 07 for 20 cycles, answer during pause → time stays 07, score unchanged. Resume → next tick arrives after the remaining divider count.
- Simultaneous events: both answer buttons rise in the same cycle as the final tick with correct = 1 → score increments by one, game ends, done pulses once.
